// File: rtl/status_flag_unit_pkg.sv
// Shared definitions for the condition-code producer: flag bit positions and
// flag_kind encodings, identical to those used by the condition checker.
package status_flag_unit_pkg;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    KIND_ARITH = 2'd0,
    KIND_LOGIC = 2'd1,
    KIND_MUL   = 2'd2,
    KIND_RSVD  = 2'd3
  } flag_kind_e;

  typedef logic [3:0] flags_t;

endpackage

// File: rtl/status_flag_unit_if.sv
// Pipeline-facing bundle of the status flag unit: EXE commit inputs, ID issue
// inputs, and the status/hazard outputs.
interface status_flag_unit_if #(
  parameter int DATA_WIDTH = 32
);
  import status_flag_unit_pkg::*;

  logic                  freeze;
  logic                  flush;
  logic                  exe_s_update;
  flag_kind_e            flag_kind;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_carry;
  logic                  alu_overflow;
  logic                  shifter_carry;
  logic                  msr_we;
  flags_t                msr_data;
  logic                  id_s_issue;
  logic                  id_cond_use;
  flags_t                status_register;
  logic                  flags_pending;
  logic                  flag_hazard;

  modport slave (
    input  freeze, flush, exe_s_update, flag_kind, alu_result, alu_carry,
           alu_overflow, shifter_carry, msr_we, msr_data, id_s_issue, id_cond_use,
    output status_register, flags_pending, flag_hazard
  );

  modport master (
    output freeze, flush, exe_s_update, flag_kind, alu_result, alu_carry,
           alu_overflow, shifter_carry, msr_we, msr_data, id_s_issue, id_cond_use,
    input  status_register, flags_pending, flag_hazard
  );

endinterface

// File: rtl/status_flag_unit_flag_pending_counter.sv
// Saturating up/down counter of flag writers in flight between ID and EXE,
// with synchronous clear and a hold input that freezes everything.
module flag_pending_counter #(
  parameter int MAX = 2,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_hold,
  input  logic         i_clear,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (!i_hold) begin
      if (i_clear) begin
        r_count <= '0;
      end else if (i_inc && !i_dec) begin
        if (r_count != W'(MAX)) r_count <= r_count + W'(1);
      end else if (i_dec && !i_inc) begin
        // A commit with nothing recorded in flight is tolerated: stay at zero.
        if (r_count != '0) r_count <= r_count - W'(1);
      end
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/status_flag_unit.sv
// Status flag unit: holds Z/C/N/V, loads them on flag-setting commits or MSR
// writes, and flags ID hazards. Optional macro: STATUS_BYPASS_EN.
module status_flag_unit
  import status_flag_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PIPE_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  status_flag_unit_if.slave bus
);

  localparam int CNT_W = $clog2(PIPE_DEPTH + 1);

  flags_t             r_status;
  flags_t             w_next_flags;
  logic [CNT_W-1:0]   w_count;
  logic               w_inc;
  logic               w_pending;

  always_comb begin
    // NOTE: every bit gets a default before the case so no path leaves it unassigned (no latch).
    w_next_flags         = r_status;
    w_next_flags[FLAG_N] = bus.alu_result[DATA_WIDTH-1];
    w_next_flags[FLAG_Z] = (bus.alu_result == '0);
    case (bus.flag_kind)
      KIND_ARITH: begin
        w_next_flags[FLAG_C] = bus.alu_carry;
        w_next_flags[FLAG_V] = bus.alu_overflow;
      end
      KIND_LOGIC: w_next_flags[FLAG_C] = bus.shifter_carry;
      KIND_MUL:   ;
      default:    w_next_flags = r_status;
    endcase
  end

  // An EXE commit always wins over a same-cycle MSR write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      r_status <= '0;
    end else if (!bus.freeze) begin
      if (bus.exe_s_update) r_status <= w_next_flags;
      else if (bus.msr_we)  r_status <= bus.msr_data;
    end
  end

  assign w_inc = bus.id_s_issue && !bus.flush;

  flag_pending_counter #(
    .MAX (PIPE_DEPTH),
    .W   (CNT_W)
  ) u_pending (
    .clk     (clk),
    .rst     (rst),
    .i_hold  (bus.freeze),
    .i_clear (bus.flush),
    .i_inc   (w_inc),
    .i_dec   (bus.exe_s_update),
    .o_count (w_count)
  );

  assign w_pending         = (w_count != '0);
  assign bus.flags_pending = w_pending;

`ifdef STATUS_BYPASS_EN
  logic w_commit;
  logic w_resolving;

  assign w_commit            = bus.exe_s_update && !bus.freeze;
  // The single outstanding writer commits now, so its flags are forwarded.
  assign w_resolving         = (w_count == CNT_W'(1)) && w_commit;
  assign bus.status_register = w_commit ? w_next_flags : r_status;
  assign bus.flag_hazard     = bus.id_cond_use && w_pending && !w_resolving;
`else
  assign bus.status_register = r_status;
  assign bus.flag_hazard     = bus.id_cond_use && w_pending;
`endif

endmodule

// File: tb/tb_status_flag_unit.sv
// Directed bench for status_flag_unit: a flag/count model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_status_flag_unit;
  import status_flag_unit_pkg::*;

  localparam int DW = 32;
  localparam int PD = 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic cmp_en;

  status_flag_unit_if #(.DATA_WIDTH(DW)) bus ();

  status_flag_unit #(.DATA_WIDTH(DW), .PIPE_DEPTH(PD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: flags as a 4-bit value, pending writers as a plain integer.
  logic [3:0] m_flags;
  int         m_count;

  function automatic logic [3:0] model_next(input logic [3:0] cur);
    logic z, c, n, v;
    z = (bus.alu_result == 0);
    n = bus.alu_result[DW-1];
    c = cur[2];
    v = cur[0];
    if (bus.flag_kind == KIND_RSVD) return cur;
    if (bus.flag_kind == KIND_ARITH) begin c = bus.alu_carry; v = bus.alu_overflow; end
    if (bus.flag_kind == KIND_LOGIC) c = bus.shifter_carry;
    return {z, c, n, v};
  endfunction

  function automatic int model_count_next(input int cur);
    int n;
    if (bus.flush) return 0;
    n = cur + (bus.id_s_issue ? 1 : 0) - (bus.exe_s_update ? 1 : 0);
    if (n > PD) n = PD;
    if (n < 0) n = 0;
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_flags <= 4'b0000;
      m_count <= 0;
    end else if (!bus.freeze) begin
      if (bus.exe_s_update) m_flags <= model_next(m_flags);
      else if (bus.msr_we)  m_flags <= bus.msr_data;
      m_count <= model_count_next(m_count);
    end
  end

  function automatic logic [3:0] exp_status();
`ifdef STATUS_BYPASS_EN
    if (bus.exe_s_update && !bus.freeze) return model_next(m_flags);
`endif
    return m_flags;
  endfunction

  function automatic logic exp_hazard();
    logic h;
    h = bus.id_cond_use && (m_count != 0);
`ifdef STATUS_BYPASS_EN
    if (m_count == 1 && bus.exe_s_update && !bus.freeze) h = 1'b0;
`endif
    return h;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_status",  32'(bus.status_register), 32'(exp_status()));
      check("cyc_pending", 32'(bus.flags_pending),   32'(m_count != 0));
      check("cyc_hazard",  32'(bus.flag_hazard),     32'(exp_hazard()));
    end
  end

  task automatic idle();
    bus.freeze        = 1'b0;
    bus.flush         = 1'b0;
    bus.exe_s_update  = 1'b0;
    bus.flag_kind     = KIND_ARITH;
    bus.alu_result    = '0;
    bus.alu_carry     = 1'b0;
    bus.alu_overflow  = 1'b0;
    bus.shifter_carry = 1'b0;
    bus.msr_we        = 1'b0;
    bus.msr_data      = 4'b0000;
    bus.id_s_issue    = 1'b0;
    bus.id_cond_use   = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input flag_kind_e kind, input logic [DW-1:0] res,
                        input logic carry, input logic ovf, input logic sh_c);
    bus.exe_s_update  = 1'b1;
    bus.flag_kind     = kind;
    bus.alu_result    = res;
    bus.alu_carry     = carry;
    bus.alu_overflow  = ovf;
    bus.shifter_carry = sh_c;
  endtask

  task automatic msr(input logic [3:0] d);
    bus.msr_we   = 1'b1;
    bus.msr_data = d;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cmp_en   = 1'b0;
    rst      = 1'b0;
    idle();
    #11;
    check("reset_status",  32'(bus.status_register), 32'h0);
    check("reset_pending", 32'(bus.flags_pending),   32'h0);
    check("reset_hazard",  32'(bus.flag_hazard),     32'h0);
    rst    = 1'b1;
    cmp_en = 1'b1;
    step();

    // Arithmetic commit of a zero result with carry out.
    commit(KIND_ARITH, '0, 1'b1, 1'b0, 1'b1);
    step(); idle();
    check("arith_zero_carry", 32'(bus.status_register), 32'hC);

    // Logical commit keeps V; multiply keeps C and V.
    msr(4'b0101); step(); idle();
    check("msr_load", 32'(bus.status_register), 32'h5);
    commit(KIND_LOGIC, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
    step(); idle();
    check("logic_kind", 32'(bus.status_register), 32'h3);
    msr(4'b0101); step(); idle();
    commit(KIND_MUL, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
    step(); idle();
    check("mul_kind", 32'(bus.status_register), 32'h7);

    // Hazard: one writer in flight, conditional instruction waits for its commit.
    bus.id_s_issue = 1'b1; step(); idle();
    bus.id_cond_use = 1'b1; #1;
    check("hazard_wait1", 32'(bus.flag_hazard), 32'h1);
    step();
    check("hazard_wait2", 32'(bus.flag_hazard), 32'h1);
    commit(KIND_ARITH, 32'h5, 1'b0, 1'b0, 1'b0); #1;
`ifdef STATUS_BYPASS_EN
    check("hazard_commit_cycle", 32'(bus.flag_hazard), 32'h0);
`else
    check("hazard_commit_cycle", 32'(bus.flag_hazard), 32'h1);
`endif
    step(); idle(); bus.id_cond_use = 1'b1; #1;
    check("hazard_cleared", 32'(bus.flag_hazard), 32'h0);
    idle();

    // Commit and MSR together: ALU flags win. Then freeze holds everything.
    commit(KIND_ARITH, 32'h1234, 1'b0, 1'b1, 1'b0);
    msr(4'b1010);
    step(); idle();
    check("commit_over_msr", 32'(bus.status_register), 32'h1);
    bus.id_s_issue = 1'b1; step(); idle();
    bus.freeze = 1'b1;
    commit(KIND_ARITH, '0, 1'b1, 1'b0, 1'b0);
    msr(4'b1111);
    bus.id_s_issue = 1'b1;
    step(); idle();
    check("freeze_status",  32'(bus.status_register), 32'h1);
    check("freeze_pending", 32'(bus.flags_pending),   32'h1);
    commit(KIND_RSVD, '0, 1'b1, 1'b1, 1'b1);
    step(); idle();
    check("rsvd_status",  32'(bus.status_register), 32'h1);
    check("rsvd_retires", 32'(bus.flags_pending),   32'h0);

    // Flush clears the count and blocks a same-cycle issue.
    bus.id_s_issue = 1'b1; step(); step();
    bus.flush = 1'b1; step(); idle();
    check("flush_clears", 32'(bus.flags_pending), 32'h0);

    // Saturation at PIPE_DEPTH, then floor at zero.
    for (int i = 0; i < 3; i++) begin bus.id_s_issue = 1'b1; step(); end
    idle();
    check("saturate_pending", 32'(bus.flags_pending), 32'h1);
    for (int i = 0; i < 2; i++) begin commit(KIND_RSVD, '0, 1'b0, 1'b0, 1'b0); step(); end
    idle();
    check("saturate_drain", 32'(bus.flags_pending), 32'h0);
    commit(KIND_RSVD, '0, 1'b0, 1'b0, 1'b0); step(); idle();
    check("floor_zero", 32'(bus.flags_pending), 32'h0);

    // Asynchronous reset mid-run with flags=1111 and two writers in flight.
    msr(4'b1111); step(); idle();
    bus.id_s_issue = 1'b1; step(); step(); idle();
    check("pre_reset_status", 32'(bus.status_register), 32'hF);
    #2 rst = 1'b0;
    #1;
    check("async_reset_status",  32'(bus.status_register), 32'h0);
    check("async_reset_pending", 32'(bus.flags_pending),   32'h0);
    #2 rst = 1'b1;
    step(); step();

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
